// File: rtl/tetris_move_scheduler.sv
// Move scheduler for the active tetromino: latches keypresses and gravity
// expiries, arbitrates between them, and drives one move at a time to the
// collision checker. Runs hard-drop loops and requests piece lock when a
// downward move is blocked.
module tetris_move_scheduler #(
    parameter int GRAV_BASE = 48,
    parameter int GRAV_STEP = 4,
    parameter int GRAV_MIN  = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [2:0] keypress,
    input  logic [3:0] level,
    output logic       mv_req,
    output logic [1:0] mv_op,
    input  logic       mv_ack,
    input  logic       mv_ok,
    output logic       lock_req,
    input  logic       lock_done,
    output logic [4:0] drop_rows,
    output logic       drop_valid,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, REQ, HARD, LOCK} state_t;

    localparam logic [1:0] OP_LEFT  = 2'd0;
    localparam logic [1:0] OP_DOWN  = 2'd2;

    state_t     state;
    logic       key_pend;
    logic [1:0] key_op;
    logic       hard_pend;
    logic       grav_pend;
    logic [1:0] cur_op;
    logic       cur_soft;
    logic       from_hard;
    logic       hard_gap;
    logic [7:0] grav_cnt;
    logic [7:0] grav_p;

    logic [7:0] p_eff;
    logic       key_ok;
    logic       key_mv;
    logic       key_hard;
    logic       grav_run;
    logic       grav_expire;
    logic       grav_clr;
    logic       req_ack;

    // Gravity period in frames, floored at GRAV_MIN; wide intermediate so a
    // high level can never wrap below zero.
    function automatic logic [7:0] grav_period(input logic [3:0] lvl);
        logic [11:0] dec;
        logic [11:0] base;
        dec  = 12'(lvl) * 12'(GRAV_STEP);
        base = 12'(GRAV_BASE);
        if (dec + 12'(GRAV_MIN) >= base)
            return 8'(GRAV_MIN);
        else
            return 8'(base - dec);
    endfunction

    // Hard-drop row count saturates instead of wrapping.
    function automatic logic [4:0] sat_inc(input logic [4:0] rows);
        return (rows == 5'd31) ? rows : rows + 5'd1;
    endfunction

    // Event strobes shared by the gravity counter and the sequencer; the
    // period is re-sampled from level only while the counter sits at zero.
    always_comb begin
        p_eff       = (grav_cnt == 8'd0) ? grav_period(level) : grav_p;
        key_ok      = (state == IDLE) || (state == REQ);
        key_mv      = key_ok && (keypress >= 3'd1) && (keypress <= 3'd3);
        key_hard    = key_ok && (keypress == 3'd4);
        grav_run    = (state == IDLE) || (state == REQ);
        grav_expire = grav_run && frame_tick && (grav_cnt == p_eff - 8'd1);
        grav_clr    = ((state == REQ) && mv_ack && (cur_op == OP_DOWN) && mv_ok && cur_soft)
                   || ((state == LOCK) && lock_done);
        req_ack     = mv_ack && mv_req;
    end

    // Gravity frame counter; frozen while a hard drop or lock is in progress.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            grav_cnt <= 8'd0;
            grav_p   <= 8'(GRAV_BASE);
        end else begin
            grav_p <= p_eff;
            if (grav_clr)
                grav_cnt <= 8'd0;
            else if (grav_run && frame_tick)
                grav_cnt <= grav_expire ? 8'd0 : grav_cnt + 8'd1;
        end
    end

    // Sequencer: pending-request latches, arbitration and handshake states.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            key_pend   <= 1'b0;
            key_op     <= OP_LEFT;
            hard_pend  <= 1'b0;
            grav_pend  <= 1'b0;
            cur_op     <= OP_LEFT;
            cur_soft   <= 1'b0;
            from_hard  <= 1'b0;
            hard_gap   <= 1'b0;
            drop_rows  <= 5'd0;
            drop_valid <= 1'b0;
        end else begin
            drop_valid <= 1'b0;
            hard_gap   <= 1'b0;
            case (state)
                IDLE: begin
                    if (hard_pend) begin
                        state     <= HARD;
                        drop_rows <= 5'd0;
                        hard_pend <= 1'b0;
                        key_pend  <= 1'b0;
                        from_hard <= 1'b1;
                        cur_op    <= OP_DOWN;
                        cur_soft  <= 1'b0;
                    end else if (key_pend) begin
                        state    <= REQ;
                        cur_op   <= key_op;
                        cur_soft <= (key_op == OP_DOWN);
                        key_pend <= 1'b0;
                    end else if (grav_pend) begin
                        state     <= REQ;
                        cur_op    <= OP_DOWN;
                        cur_soft  <= 1'b0;
                        grav_pend <= 1'b0;
                    end
                end
                REQ: begin
                    if (mv_ack) begin
                        if (cur_op != OP_DOWN || mv_ok) begin
                            state <= IDLE;
                        end else begin
                            state     <= LOCK;
                            from_hard <= 1'b0;
                        end
                    end
                end
                HARD: begin
                    if (req_ack) begin
                        if (mv_ok) begin
                            drop_rows <= sat_inc(drop_rows);
                            hard_gap  <= 1'b1;
                        end else begin
                            state <= LOCK;
                        end
                    end
                end
                LOCK: begin
                    if (lock_done) begin
                        state      <= IDLE;
                        key_pend   <= 1'b0;
                        hard_pend  <= 1'b0;
                        drop_valid <= from_hard;
                    end
                end
                default: state <= IDLE;
            endcase

            // New inputs win over a same-cycle arbitration clear.
            if (key_mv) begin
                key_pend <= 1'b1;
                key_op   <= 2'(keypress - 3'd1);
            end
            if (key_hard)
                hard_pend <= 1'b1;
            if (grav_clr)
                grav_pend <= 1'b0;
            else if (grav_expire)
                grav_pend <= 1'b1;
        end
    end

    // Outputs decoded from registered state; the gap flag makes the
    // hard-drop request drop for one cycle after every committed step.
    always_comb begin
        mv_req   = (state == REQ) || ((state == HARD) && !hard_gap);
        mv_op    = mv_req ? cur_op : 2'd0;
        lock_req = (state == LOCK);
        busy     = (state != IDLE);
    end

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// Scoreboard bench for tetris_move_scheduler: stimulus pushes expected move,
// lock and drop events; a monitor pops and compares as the DUT emits them.
module tb_tetris_move_scheduler;

    localparam logic [1:0] EV_MOVE = 2'd0;
    localparam logic [1:0] EV_LOCK = 2'd1;
    localparam logic [1:0] EV_DROP = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [4:0] val;
    } ev_t;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic [2:0] keypress;
    logic [3:0] level;
    logic       mv_req;
    logic [1:0] mv_op;
    logic       mv_ack;
    logic       mv_ok;
    logic       lock_req;
    logic       lock_done;
    logic [4:0] drop_rows;
    logic       drop_valid;
    logic       busy;

    ev_t  exp_q[$];
    logic ok_q[$];
    logic auto_ack;
    logic lock_prev;
    int   n_moves;
    int   total;
    int   bad;

    tetris_move_scheduler #(.GRAV_BASE(48), .GRAV_STEP(4), .GRAV_MIN(2)) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keypress(keypress),
        .level(level), .mv_req(mv_req), .mv_op(mv_op), .mv_ack(mv_ack), .mv_ok(mv_ok),
        .lock_req(lock_req), .lock_done(lock_done), .drop_rows(drop_rows),
        .drop_valid(drop_valid), .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic got(input logic [1:0] kind, input logic [4:0] val);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d val=%0d expected none", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.val !== val) begin
                bad++;
                $display("FAIL event: got kind=%0d val=%0d expected kind=%0d val=%0d",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [4:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        idle(3);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input logic [2:0] code);
        keypress = code;
        cycle();
        keypress = 3'd0;
    endtask

    task automatic pulse_lock_done();
        lock_done = 1'b1;
        cycle();
        lock_done = 1'b0;
    endtask

    task automatic wait_lock(input string name);
        int n;
        n = 0;
        while (!lock_req && n < 200) begin
            cycle();
            n++;
        end
        check(name, {31'd0, lock_req}, 32'd1);
    endtask

    // Checker model: acks each request in its first cycle, result from ok_q.
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (mv_ack) begin
                mv_ack = 1'b0;
                mv_ok  = 1'b0;
            end else if (auto_ack && mv_req && !Reset) begin
                mv_ack = 1'b1;
                if (ok_q.size() > 0) mv_ok = ok_q.pop_front();
                else                 mv_ok = 1'b1;
            end
        end
    end

    // Monitor: turns DUT outputs into events and compares with the queue.
    initial begin
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                if (mv_req && mv_ack) begin
                    n_moves++;
                    got(EV_MOVE, {3'd0, mv_op});
                end
                if (lock_req && !lock_prev) got(EV_LOCK, 5'd0);
                if (drop_valid) got(EV_DROP, drop_rows);
            end
            lock_prev = lock_req;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        total = 0; bad = 0; n_moves = 0; lock_prev = 1'b0;
        auto_ack = 1'b1;
        Reset = 1'b1; frame_tick = 1'b0; keypress = 3'd0; level = 4'd0;
        mv_ack = 1'b0; mv_ok = 1'b0; lock_done = 1'b0;
        idle(3);
        check("rst_mv_req", {31'd0, mv_req}, 32'd0);
        check("rst_mv_op", {30'd0, mv_op}, 32'd0);
        check("rst_lock_req", {31'd0, lock_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_drop_rows", {27'd0, drop_rows}, 32'd0);
        check("rst_drop_valid", {31'd0, drop_valid}, 32'd0);
        Reset = 1'b0;
        cycle();

        // Level 0: gravity every 48 frames
        ticks(47);
        check("grav48_early", n_moves, 0);
        expect_ev(EV_MOVE, 5'd2);
        tick();
        idle(3);
        check("grav48_fire", n_moves, 1);
        check("grav48_busy", {31'd0, busy}, 32'd0);
        ticks(47);
        check("grav48_early2", n_moves, 1);
        expect_ev(EV_MOVE, 5'd2);
        tick();
        idle(3);
        check("grav48_fire2", n_moves, 2);

        // Level 15 floors at 2 frames; level 5 gives 28
        level = 4'd15;
        base = n_moves;
        for (int i = 0; i < 3; i++) expect_ev(EV_MOVE, 5'd2);
        ticks(6);
        idle(3);
        check("grav_l15", n_moves - base, 3);
        level = 4'd5;
        base = n_moves;
        ticks(27);
        check("grav_l5_early", n_moves - base, 0);
        expect_ev(EV_MOVE, 5'd2);
        tick();
        idle(3);
        check("grav_l5_fire", n_moves - base, 1);

        // Key and gravity expiry in the same cycle: left first, then down
        level = 4'd15;
        tick();
        base = n_moves;
        expect_ev(EV_MOVE, 5'd0);
        expect_ev(EV_MOVE, 5'd2);
        frame_tick = 1'b1;
        keypress = 3'd1;
        cycle();
        frame_tick = 1'b0;
        keypress = 3'd0;
        idle(10);
        check("key_grav_order", n_moves - base, 2);

        // Two keys latched behind a stalled request: only the newer is issued
        auto_ack = 1'b0;
        base = n_moves;
        expect_ev(EV_MOVE, 5'd1);
        press(3'd2);
        idle(2);
        check("stall_mv_req", {31'd0, mv_req}, 32'd1);
        check("stall_mv_op", {30'd0, mv_op}, 32'd1);
        press(3'd1);
        press(3'd2);
        expect_ev(EV_MOVE, 5'd1);
        auto_ack = 1'b1;
        idle(10);
        check("overwrite_key", n_moves - base, 2);

        // Hard drop: seven committed steps then blocked
        base = n_moves;
        for (int i = 0; i < 7; i++) ok_q.push_back(1'b1);
        ok_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) expect_ev(EV_MOVE, 5'd2);
        expect_ev(EV_LOCK, 5'd0);
        press(3'd4);
        wait_lock("hard_lock");
        check("hard_moves", n_moves - base, 8);
        expect_ev(EV_DROP, 5'd7);
        pulse_lock_done();
        idle(3);
        check("hard_rows", {27'd0, drop_rows}, 32'd7);
        check("hard_busy", {31'd0, busy}, 32'd0);

        // Soft down blocked; keys during lock are discarded
        base = n_moves;
        ok_q.push_back(1'b0);
        expect_ev(EV_MOVE, 5'd2);
        expect_ev(EV_LOCK, 5'd0);
        press(3'd3);
        wait_lock("soft_lock");
        press(3'd1);
        press(3'd2);
        pulse_lock_done();
        idle(10);
        check("soft_moves", n_moves - base, 1);
        check("soft_busy", {31'd0, busy}, 32'd0);

        // Reset mid-handshake, then gravity waits a full period (level 3: 36)
        level = 4'd3;
        ticks(10);
        auto_ack = 1'b0;
        base = n_moves;
        press(3'd1);
        idle(2);
        check("pre_rst_req", {31'd0, mv_req}, 32'd1);
        #1;
        Reset = 1'b1;
        #1;
        check("async_mv_req", {31'd0, mv_req}, 32'd0);
        check("async_lock_req", {31'd0, lock_req}, 32'd0);
        check("async_busy", {31'd0, busy}, 32'd0);
        idle(2);
        Reset = 1'b0;
        auto_ack = 1'b1;
        cycle();
        ticks(35);
        check("post_rst_early", n_moves - base, 0);
        expect_ev(EV_MOVE, 5'd2);
        tick();
        idle(3);
        check("post_rst_fire", n_moves - base, 1);

        idle(5);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
